// File: rtl/ps2_kbd_decoder.sv
// PS/2 keyboard receiver: oversampled frame capture, E0/F0 prefix folding, output FIFO.
// Optional PS2_KEY_BITMAP_EN adds a per-key down bitmap with a query port.
module ps2_kbd_decoder #(
    parameter int FIFO_AW        = 3,
    parameter int SYNC_STAGES    = 3,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_code,
    output logic       out_brk,
    output logic       out_ext,
    output logic       overflow,
    input  logic       clr_overflow,
    output logic [7:0] err_cnt,
    output logic       busy
`ifdef PS2_KEY_BITMAP_EN
    ,
    input  logic [7:0] query_code,
    input  logic       query_ext,
    output logic       key_down
`endif
);

    localparam int DEPTH = 1 << FIFO_AW;
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0]    TO_LIMIT = TO_W'(TIMEOUT_CYCLES);
    localparam logic [FIFO_AW:0]   FULL_CNT = (FIFO_AW + 1)'(DEPTH);
    localparam logic [3:0]         BIT_STOP = 4'd10;

    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] data_sync;
    logic                   sample;
    logic                   bit_in;

    logic [3:0]             bit_cnt;
    logic [9:0]             frame_buf;
    logic                   frame_done;
    logic                   frame_ok;
    logic                   frame_err;
    logic [7:0]             rx_byte;

    logic [TO_W-1:0]        to_cnt;
    logic                   timeout_hit;

    logic                   ext_flag;
    logic                   brk_flag;
    logic                   key_event;

    logic [9:0]             mem [DEPTH];
    logic [FIFO_AW-1:0]     wptr;
    logic [FIFO_AW-1:0]     rptr;
    logic [FIFO_AW:0]       count;
    logic                   full;
    logic                   do_pop;
    logic                   push_ok;

    // Index 0 is the newest sample; the top stage is the oldest.
    always_ff @(posedge clk) begin
        if (reset) begin
            clk_sync  <= '1;
            data_sync <= '1;
        end else begin
            clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
            data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data};
        end
    end

    assign sample = clk_sync[SYNC_STAGES-1] & ~clk_sync[SYNC_STAGES-2];
    assign bit_in = data_sync[SYNC_STAGES-1];

    assign busy       = (bit_cnt != 4'd0);
    assign frame_done = sample && (bit_cnt == BIT_STOP);
    assign frame_ok   = frame_done && !frame_buf[0] && bit_in && (^frame_buf[9:1]);
    assign frame_err  = frame_done && !frame_ok;
    assign rx_byte    = frame_buf[8:1];

    always_ff @(posedge clk) begin
        if (reset) begin
            bit_cnt <= 4'd0;
        end else if (sample) begin
            if (bit_cnt == BIT_STOP) begin
                bit_cnt <= 4'd0;
            end else begin
                bit_cnt <= bit_cnt + 4'd1;
            end
        end else if (timeout_hit) begin
            bit_cnt <= 4'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (sample && (bit_cnt != BIT_STOP)) begin
            frame_buf[bit_cnt] <= bit_in;
        end
    end

    assign timeout_hit = busy && !sample && (to_cnt == TO_LIMIT);

    always_ff @(posedge clk) begin
        if (reset || sample || !busy || timeout_hit) begin
            to_cnt <= '0;
        end else begin
            to_cnt <= to_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            err_cnt <= 8'd0;
        end else if ((frame_err || timeout_hit) && (err_cnt != 8'hFF)) begin
            err_cnt <= err_cnt + 8'd1;
        end
    end

    assign key_event = frame_ok && (rx_byte != 8'hE0) && (rx_byte != 8'hF0);

    // Flags clear on every key event, even one the FIFO has to drop.
    always_ff @(posedge clk) begin
        if (reset) begin
            ext_flag <= 1'b0;
            brk_flag <= 1'b0;
        end else if (frame_ok) begin
            if (rx_byte == 8'hE0) begin
                ext_flag <= 1'b1;
            end else if (rx_byte == 8'hF0) begin
                brk_flag <= 1'b1;
            end else begin
                ext_flag <= 1'b0;
                brk_flag <= 1'b0;
            end
        end
    end

    assign out_valid = (count != '0);
    assign full      = (count == FULL_CNT);
    assign do_pop    = out_valid && out_ready;
    assign push_ok   = key_event && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wptr] <= {ext_flag, brk_flag, rx_byte};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push_ok) begin
                wptr <= wptr + 1'b1;
            end
            if (do_pop) begin
                rptr <= rptr + 1'b1;
            end
            if (push_ok && !do_pop) begin
                count <= count + 1'b1;
            end else if (do_pop && !push_ok) begin
                count <= count - 1'b1;
            end
        end
    end

    // A new drop outranks a same-cycle clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (key_event && full && !do_pop) begin
            overflow <= 1'b1;
        end else if (clr_overflow) begin
            overflow <= 1'b0;
        end
    end

    assign {out_ext, out_brk, out_code} = mem[rptr];

`ifdef PS2_KEY_BITMAP_EN
    logic [255:0] down_norm;
    logic [255:0] down_ext;

    always_ff @(posedge clk) begin
        if (reset) begin
            down_norm <= '0;
            down_ext  <= '0;
        end else if (key_event) begin
            if (ext_flag) begin
                down_ext[rx_byte] <= !brk_flag;
            end else begin
                down_norm[rx_byte] <= !brk_flag;
            end
        end
    end

    assign key_down = query_ext ? down_ext[query_code] : down_norm[query_code];
`endif

endmodule
